// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing monitor.
// Samples active-low hsync/vsync on the pixel clock, rebuilds the raster
// position, validates line/frame lengths and declares lock after a run of
// clean frames. Pixel coordinates are valid only while locked.
// Optional build macro: VGA_DEC_ERRCNT_EN adds a saturating err_count output.
module vga_sync_decoder #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACT       = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACT       = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       err_line,
  output logic       err_frame,
  output logic [7:0] frame_cnt
`ifdef VGA_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_OFF    = 10'(H_SYNC + H_BP);
  localparam logic [9:0] V_OFF    = 10'(V_SYNC + V_BP);
  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] CNT_MAX  = 10'd1023;
  localparam logic [9:0] CNT_PRE  = 10'd1022;
  localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Sync input pipeline (idle level is high)
  logic hs_q, hs_qq;
  logic vs_q, vs_qq;
  logic hfall, vfall;

  // Raster counters and length checking
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_armed_q, h_armed_d;
  logic       v_armed_q, v_armed_d;
  logic       err_line_q, err_line_d;
  logic       err_frame_q, err_frame_d;
  logic       frame_start_q, frame_start_d;
  logic       ev_err;

  // Lock FSM
  state_t     state_q, state_d;
  logic [7:0] good_q, good_d;
  logic       locked_q, locked_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Active-region outputs
  logic [9:0] hx, vy;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;

  assign hfall  = hs_qq & ~hs_q;
  assign vfall  = vs_qq & ~vs_q;
  // The FSM and arming logic react to the registered error pulses so that
  // locked drops one clock after the visible error pulse.
  assign ev_err = err_line_q | err_frame_q;

  // Two-stage sync sampling; reset parks both stages at the idle level
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      hs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
    end else begin
      hs_q  <= hsync;
      hs_qq <= hs_q;
      vs_q  <= vsync;
      vs_qq <= vs_q;
    end
  end

  // Horizontal/vertical counters, length checks and timeouts
  always_comb begin
    h_cnt_d       = h_cnt_q;
    h_armed_d     = h_armed_q;
    err_line_d    = 1'b0;
    v_cnt_d       = v_cnt_q;
    v_armed_d     = v_armed_q;
    err_frame_d   = 1'b0;
    frame_start_d = vfall;

    // A line is only judged once a previous hfall gave a reference point.
    if (hfall) begin
      h_cnt_d   = 10'd0;
      h_armed_d = 1'b1;
      if (h_armed_q && (h_cnt_q != H_LAST)) begin
        err_line_d = 1'b1;
      end
    end else if (h_cnt_q == CNT_PRE) begin
      h_cnt_d    = CNT_MAX;
      err_line_d = 1'b1;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    // vfall wins over a coincident hfall: the new frame starts at row 0.
    if (vfall) begin
      v_cnt_d   = 10'd0;
      v_armed_d = 1'b1;
      if (v_armed_q && (v_cnt_q != V_LAST)) begin
        err_frame_d = 1'b1;
      end
    end else if (hfall) begin
      if (v_cnt_q == CNT_PRE) begin
        v_cnt_d     = CNT_MAX;
        err_frame_d = 1'b1;
      end else if (v_cnt_q != CNT_MAX) begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end

    // Losing lock discards the reference edges, so the next edge of each
    // kind is treated as a fresh starting point rather than checked.
    if (ev_err) begin
      h_armed_d = 1'b0;
      v_armed_d = 1'b0;
    end
  end

  // Counter and event-pulse registers
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      h_armed_q     <= 1'b0;
      v_armed_q     <= 1'b0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_armed_q     <= h_armed_d;
      v_armed_q     <= v_armed_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Lock FSM next-state: errors always take priority over a coincident vfall
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (frame_start_q && !ev_err) begin
          state_d = ACQUIRE;
          good_d  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (ev_err) begin
          state_d = UNLOCKED;
          good_d  = 8'd0;
        end else if (frame_start_q) begin
          good_d = good_q + 8'd1;
          if ((good_q + 8'd1) >= LOCK_N) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (ev_err) begin
          state_d = UNLOCKED;
          good_d  = 8'd0;
        end else if (frame_start_q) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = 8'd0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // Lock FSM state and its registered outputs
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q     <= UNLOCKED;
      good_q      <= 8'd0;
      locked_q    <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Active-region decode; negative offsets wrap large and fail the compare
  always_comb begin
    hx         = h_cnt_q - H_OFF;
    vy         = v_cnt_q - V_OFF;
    video_on_d = locked_q && (hx < H_ACT_W) && (vy < V_ACT_W);
    pixel_x_d  = video_on_d ? hx : 10'd0;
    pixel_y_d  = video_on_d ? vy : 10'd0;
  end

  // Registered pixel position, aligned with video_on
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      video_on_q <= 1'b0;
      pixel_x_q  <= 10'd0;
      pixel_y_q  <= 10'd0;
    end else begin
      video_on_q <= video_on_d;
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating error tally; simultaneous line and frame errors count once
  always_comb begin
    err_count_d = err_count_q;
    if (ev_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Error tally register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced raster (30x16 clocks/lines)
// so many frames fit in a short run. Expected event pulses and timed output
// probes are queued by the stimulus and consumed by an independent monitor.
module tb_vga_sync_decoder;
  localparam int GH_SYNC  = 4;
  localparam int GH_BP    = 3;
  localparam int GH_ACT   = 16;
  localparam int GH_TOTAL = 30;
  localparam int GV_SYNC  = 2;
  localparam int GV_BP    = 3;
  localparam int GV_ACT   = 8;
  localparam int GV_TOTAL = 16;
  localparam int NONE     = -1;

  logic       clk = 1'b0;
  logic       RSTN;
  logic       hsync;
  logic       vsync;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       locked;
  logic       frame_start;
  logic       err_line;
  logic       err_frame;
  logic [7:0] frame_cnt;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  vga_sync_decoder #(
    .H_SYNC(GH_SYNC), .H_BP(GH_BP), .H_ACT(GH_ACT), .H_TOTAL(GH_TOTAL),
    .V_SYNC(GV_SYNC), .V_BP(GV_BP), .V_ACT(GV_ACT), .V_TOTAL(GV_TOTAL),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .RSTN(RSTN), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .locked(locked), .frame_start(frame_start), .err_line(err_line),
    .err_frame(err_frame), .frame_cnt(frame_cnt)
`ifdef VGA_DEC_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       fs;
    logic       el;
    logic       ef;
    logic       lk;
    logic [7:0] fc;
  } ev_t;

  typedef struct {
    int          stamp;
    logic [32:0] vec;   // {video_on, locked, fs, el, ef, px, py, fc}
  } probe_t;

  ev_t    exp_ev[$];
  probe_t probe_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic push_ev(input logic fs, input logic el, input logic ef,
                         input logic lk, input logic [7:0] fc);
    ev_t e;
    e.fs = fs; e.el = el; e.ef = ef; e.lk = lk; e.fc = fc;
    exp_ev.push_back(e);
  endtask

  task automatic push_probe(input int stamp, input logic von, input logic lk,
                            input logic [9:0] px, input logic [9:0] py,
                            input logic [7:0] fc);
    probe_t p;
    p.stamp = stamp;
    p.vec   = {von, lk, 3'b000, px, py, fc};
    probe_q.push_back(p);
  endtask

  // Raster generator. mod_line/mod_len stretch or shrink one line,
  // rst_line pulses RSTN for one clock mid-line, pix enables pixel probes.
  task automatic gen_frame(input int n_lines, input int mod_line, input int mod_len,
                           input bit pix, input logic [7:0] fc, input int rst_line);
    for (int v = 0; v < n_lines; v++) begin
      int len;
      len = (v == mod_line) ? mod_len : GH_TOTAL;
      for (int h = 0; h < len; h++) begin
        @(posedge clk); #1;
        hsync = (h < GH_SYNC) ? 1'b0 : 1'b1;
        vsync = (v < GV_SYNC) ? 1'b0 : 1'b1;
        RSTN  = 1'b1;
        if (v == rst_line && h == 15) begin
          RSTN = 1'b0;
          push_probe(cyc + 1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
        end
        if (h == 0 && mod_line >= 0 && v == mod_line + 1 && mod_len < GH_TOTAL)
          push_probe(cyc + 3, 1'b0, 1'b0, 10'd0, 10'd0, fc);
        if (h == 0 && v == mod_line && mod_len > GH_TOTAL)
          push_probe(cyc + 1026, 1'b0, 1'b0, 10'd0, 10'd0, fc);
        if (pix) begin
          if (v == 5 && h == 6)   push_probe(cyc + 3, 1'b0, 1'b1, 10'd0,  10'd0, fc);
          if (v == 5 && h == 7)   push_probe(cyc + 3, 1'b1, 1'b1, 10'd0,  10'd0, fc);
          if (v == 8 && h == 12)  push_probe(cyc + 3, 1'b1, 1'b1, 10'd5,  10'd3, fc);
          if (v == 12 && h == 22) push_probe(cyc + 3, 1'b1, 1'b1, 10'd15, 10'd7, fc);
          if (v == 12 && h == 23) push_probe(cyc + 3, 1'b0, 1'b1, 10'd0,  10'd0, fc);
        end
      end
    end
  endtask

  // Monitor: compares event pulses in order and timed probes by stamp
  initial begin
    ev_t         e;
    probe_t      p;
    logic [32:0] got;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1 || err_line === 1'b1 || err_frame === 1'b1) begin
        checks++;
        if (exp_ev.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected cyc=%0d got fs=%b el=%b ef=%b lk=%b fc=%0d, required no event",
                   cyc, frame_start, err_line, err_frame, locked, frame_cnt);
        end else begin
          e = exp_ev.pop_front();
          if ({frame_start, err_line, err_frame, locked, frame_cnt} !==
              {e.fs, e.el, e.ef, e.lk, e.fc}) begin
            errors++;
            $display("FAIL event cyc=%0d got fs=%b el=%b ef=%b lk=%b fc=%0d, required fs=%b el=%b ef=%b lk=%b fc=%0d",
                     cyc, frame_start, err_line, err_frame, locked, frame_cnt,
                     e.fs, e.el, e.ef, e.lk, e.fc);
          end
        end
      end
      while (probe_q.size() > 0 && probe_q[0].stamp <= cyc) begin
        p   = probe_q.pop_front();
        got = {video_on, locked, frame_start, err_line, err_frame, pixel_x, pixel_y, frame_cnt};
        checks++;
        if (p.stamp != cyc || got !== p.vec) begin
          errors++;
          $display("FAIL probe stamp=%0d cyc=%0d got von=%b lk=%b fs/el/ef=%b px=%0d py=%0d fc=%0d, required von=%b lk=%b fs/el/ef=%b px=%0d py=%0d fc=%0d",
                   p.stamp, cyc, got[32], got[31], got[30:28], got[27:18], got[17:8], got[7:0],
                   p.vec[32], p.vec[31], p.vec[30:28], p.vec[27:18], p.vec[17:8], p.vec[7:0]);
        end
      end
    end
  end

  initial begin
    RSTN  = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_probe(cyc + 1, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0);
    @(posedge clk); #1;
    RSTN = 1'b1;

    // Acquire: lock after the third vfall, count the fourth
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 1, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 1, 8'd1, NONE);

    // Short line while locked, then relock
    push_ev(1, 0, 0, 1, 8'd1);
    push_ev(0, 1, 0, 1, 8'd2); gen_frame(GV_TOTAL, 6, GH_TOTAL - 1, 0, 8'd2, NONE);
    push_ev(1, 0, 0, 0, 8'd2); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd2, NONE);
    push_ev(1, 0, 0, 0, 8'd2); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd2, NONE);
    push_ev(1, 0, 0, 0, 8'd2); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd2, NONE);

    // hsync stuck high for 1100 clocks: one timeout error only
    push_ev(1, 0, 0, 1, 8'd2);
    push_ev(0, 1, 0, 1, 8'd3); gen_frame(GV_TOTAL, 3, GH_SYNC + 1100, 0, 8'd3, NONE);
    push_ev(1, 0, 0, 0, 8'd3); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd3, NONE);
    push_ev(1, 0, 0, 0, 8'd3); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd3, NONE);
    push_ev(1, 0, 0, 0, 8'd3); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd3, NONE);

    // One frame a line short: error at the following vfall
    push_ev(1, 0, 0, 1, 8'd3); gen_frame(GV_TOTAL - 1, NONE, GH_TOTAL, 0, 8'd4, NONE);
    push_ev(1, 0, 1, 1, 8'd4); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd4, NONE);
    push_ev(1, 0, 0, 0, 8'd4); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd4, NONE);
    push_ev(1, 0, 0, 0, 8'd4); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd4, NONE);
    push_ev(1, 0, 0, 0, 8'd4); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd4, NONE);

    // One-clock reset mid-frame while locked, then normal reacquire
    push_ev(1, 0, 0, 1, 8'd4); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd5, 8);
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 0, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 0, 8'd0, NONE);
    push_ev(1, 0, 0, 1, 8'd0); gen_frame(GV_TOTAL, NONE, GH_TOTAL, 1, 8'd1, NONE);

    hsync = 1'b1;
    vsync = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (exp_ev.size() != 0 || probe_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events and %0d probes still pending, required 0 and 0",
               exp_ev.size(), probe_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
